// File: rtl/hash_byte_unpacker_pkg.sv
// Shared SHA-256 sizing constants and the unpacker state encoding.
// The digest sizes are also used by the SHA-256 core and the receive-side packer.
package hash_byte_unpacker_pkg;

    localparam int SHA256_DIGEST_W     = 256;
    localparam int SHA256_DIGEST_BYTES = 32;

    localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
    localparam logic [2:0] ST_SEND_ENC      = 3'd1;
    localparam logic [2:0] ST_WAIT_DONE_ENC = 3'd2;
    localparam logic [2:0] ST_GAP_ENC       = 3'd3;
    localparam logic [2:0] ST_FINISH_ENC    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = ST_IDLE_ENC,
        ST_SEND      = ST_SEND_ENC,
        ST_WAIT_DONE = ST_WAIT_DONE_ENC,
        ST_GAP       = ST_GAP_ENC,
        ST_FINISH    = ST_FINISH_ENC
    } unpacker_state_e;

endpackage

// File: rtl/hash_byte_unpacker.sv
// Unpacks one SHA-256 digest into a big-endian byte stream for the UART
// transmitter, issuing each byte only after the previous one has been sent.
module hash_byte_unpacker
    import hash_byte_unpacker_pkg::*;
#(
    parameter int NUM_BYTES  = SHA256_DIGEST_BYTES,
    parameter int GAP_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*NUM_BYTES-1:0] digest_in,
    input  logic                   digest_valid,
    input  logic                   tx_done,
    output logic                   tx_dv,
    output logic [7:0]             tx_byte,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int DW    = 8 * NUM_BYTES;
    localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    // The gap counter only ever holds GAP_CYCLES-1 down to 0.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    unpacker_state_e  state;
    logic [DW-1:0]    shreg;
    logic [CNT_W-1:0] byte_cnt;
    logic [GAP_W-1:0] gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            tx_dv    <= 1'b0;
            tx_byte  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            tx_dv   <= 1'b0;
            done    <= 1'b0;
            // Any digest offered outside IDLE (FINISH included) is dropped and flagged.
            overrun <= digest_valid && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (digest_valid) begin
                        shreg    <= digest_in;
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    tx_dv   <= 1'b1;
                    tx_byte <= shreg[DW-1 -: 8];
                    state   <= ST_WAIT_DONE;
                end

                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        if (byte_cnt == LAST_IDX) begin
                            state <= ST_FINISH;
                        end else begin
                            shreg    <= shreg << 8;
                            byte_cnt <= byte_cnt + CNT_W'(1);
                            if (GAP_CYCLES > 0) begin
                                gap_cnt <= GAP_LOAD;
                                state   <= ST_GAP;
                            end else begin
                                state <= ST_SEND;
                            end
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end

                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_byte_unpacker.sv
// Bench for hash_byte_unpacker: one instance without pacing gap, one with a
// three-cycle gap, both checked every cycle against an event-timing model.
module tb_hash_byte_unpacker;
    import hash_byte_unpacker_pkg::*;

    localparam int NB    = SHA256_DIGEST_BYTES;
    localparam int DW    = 8 * NB;
    localparam int GAP_B = 3;

    localparam logic [DW-1:0] ABC    = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [DW-1:0] SEQ    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [DW-1:0] ALL_FF = {DW{1'b1}};

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] digest_in    [2];
    logic          digest_valid [2];
    logic          stray_done   [2];
    logic          resp_done    [2] = '{1'b0, 1'b0};
    logic          tx_done_w    [2];
    logic          tx_dv_o      [2];
    logic [7:0]    tx_byte_o    [2];
    logic          busy_o       [2];
    logic          done_o       [2];
    logic          overrun_o    [2];

    int checks = 0;
    int errors = 0;

    assign tx_done_w[0] = resp_done[0] | stray_done[0];
    assign tx_done_w[1] = resp_done[1] | stray_done[1];

    hash_byte_unpacker #(.NUM_BYTES(NB), .GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .digest_in(digest_in[0]), .digest_valid(digest_valid[0]),
        .tx_done(tx_done_w[0]), .tx_dv(tx_dv_o[0]), .tx_byte(tx_byte_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .overrun(overrun_o[0])
    );

    hash_byte_unpacker #(.NUM_BYTES(NB), .GAP_CYCLES(GAP_B)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .digest_in(digest_in[1]), .digest_valid(digest_valid[1]),
        .tx_done(tx_done_w[1]), .tx_dv(tx_dv_o[1]), .tx_byte(tx_byte_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .overrun(overrun_o[1])
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int gapOf(input int d);
        return (d == 1) ? GAP_B : 0;
    endfunction

    // Inputs as seen by the DUT at each rising edge; cyc numbers those edges.
    int            cyc = 0;
    logic [DW-1:0] s_dig  [2];
    logic          s_dv   [2];
    logic          s_done [2];

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        s_dig     <= digest_in;
        s_dv      <= digest_valid;
        s_done    <= tx_done_w;
    end

    // Model: byte i of an accepted digest is due one edge after acceptance or
    // one edge (plus the gap) after byte i-1's completion; done one edge after the last.
    bit            m_active  [2];
    bit            m_await   [2];
    int            m_idx     [2];
    int            m_next_dv [2];
    int            m_done_at [2];
    logic [DW-1:0] m_dig     [2];
    logic          exp_dv    [2];
    logic [7:0]    exp_byte  [2];
    logic          exp_busy  [2];
    logic          exp_done  [2];
    logic          exp_ovr   [2];

    logic [7:0] cap0 [$];
    logic [7:0] cap1 [$];
    int         ovr_cnt    [2] = '{0, 0};
    int         resp_delay [2] = '{10, 1};
    int         resp_cnt   [2] = '{0, 0};
    int         done_edge1 = -1;
    int         gap_used   = -1;

    always @(negedge clk) begin
        int e;
        bit was_active;
        e = cyc;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_active[d]  = 1'b0;
                m_await[d]   = 1'b0;
                m_idx[d]     = 0;
                m_next_dv[d] = -1;
                m_done_at[d] = -1;
                exp_dv[d]    = 1'b0;
                exp_byte[d]  = 8'h00;
                exp_busy[d]  = 1'b0;
                exp_done[d]  = 1'b0;
                exp_ovr[d]   = 1'b0;
                resp_cnt[d]  = 0;
            end else begin
                was_active  = m_active[d];
                exp_ovr[d]  = s_dv[d] && was_active;
                exp_dv[d]   = 1'b0;
                exp_done[d] = 1'b0;
                if (s_done[d] && m_await[d]) begin
                    m_await[d] = 1'b0;
                    if (m_idx[d] == NB) m_done_at[d] = e + 1;
                    else                m_next_dv[d] = e + 1 + gapOf(d);
                end
                if (m_next_dv[d] == e) begin
                    exp_dv[d]    = 1'b1;
                    exp_byte[d]  = m_dig[d][DW-1-8*m_idx[d] -: 8];
                    m_idx[d]     = m_idx[d] + 1;
                    m_await[d]   = 1'b1;
                    m_next_dv[d] = -1;
                end
                if (m_done_at[d] == e) begin
                    exp_done[d]  = 1'b1;
                    exp_busy[d]  = 1'b0;
                    m_active[d]  = 1'b0;
                    m_done_at[d] = -1;
                end
                if (s_dv[d] && !was_active) begin
                    m_dig[d]     = s_dig[d];
                    m_idx[d]     = 0;
                    m_active[d]  = 1'b1;
                    exp_busy[d]  = 1'b1;
                    m_next_dv[d] = e + 1;
                end
            end

            checkOutput($sformatf("tx_dv[%0d]", d),   tx_dv_o[d],   exp_dv[d]);
            checkOutput($sformatf("tx_byte[%0d]", d), tx_byte_o[d], exp_byte[d]);
            checkOutput($sformatf("busy[%0d]", d),    busy_o[d],    exp_busy[d]);
            checkOutput($sformatf("done[%0d]", d),    done_o[d],    exp_done[d]);
            checkOutput($sformatf("overrun[%0d]", d), overrun_o[d], exp_ovr[d]);

            if (tx_dv_o[d]) begin
                if (d == 0) cap0.push_back(tx_byte_o[d]);
                else        cap1.push_back(tx_byte_o[d]);
                if (d == 1 && rst_n && done_edge1 != gap_used) begin
                    checkOutput("gap_spacing", e - done_edge1, GAP_B + 1);
                    gap_used = done_edge1;
                end
            end
            if (d == 1 && rst_n && s_done[1]) done_edge1 = e;
            if (overrun_o[d]) ovr_cnt[d]++;

            // Transmitter stand-in: answer each tx_dv with a tx_done pulse resp_delay cycles later.
            resp_done[d] = 1'b0;
            if (rst_n && tx_dv_o[d]) begin
                resp_cnt[d] = resp_delay[d];
            end else if (resp_cnt[d] > 0) begin
                resp_cnt[d]--;
                if (resp_cnt[d] == 0) resp_done[d] = 1'b1;
            end
        end
    end

    function automatic logic [DW-1:0] packCap(input logic [7:0] q[$], input int base);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++)
            if (base + i < q.size()) r[DW-1-8*i -: 8] = q[base + i];
        return r;
    endfunction

    task automatic applyStimulus(input int d, input logic [DW-1:0] dig, input bit stray_in_send);
        @(negedge clk);
        digest_in[d]    = dig;
        digest_valid[d] = 1'b1;
        @(negedge clk);
        digest_valid[d] = 1'b0;
        if (stray_in_send) begin
            stray_done[d] = 1'b1;
            @(negedge clk);
            stray_done[d] = 1'b0;
        end
    endtask

    task automatic waitBytes(input int d, input int n);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (((d == 0) ? cap0.size() : cap1.size()) >= n) return;
        end
        checkOutput("wait_bytes_timeout", (d == 0) ? cap0.size() : cap1.size(), n);
    endtask

    task automatic waitDone(input int d);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (done_o[d]) return;
        end
        checkOutput("wait_done_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int base;
        int obase;
        for (int d = 0; d < 2; d++) begin
            digest_in[d]    = '0;
            digest_valid[d] = 1'b0;
            stray_done[d]   = 1'b0;
        end

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_tx_dv",   tx_dv_o[0],   1'b0);
        checkOutput("reset_tx_byte", tx_byte_o[0], 8'h00);
        checkOutput("reset_busy",    busy_o[0],    1'b0);
        checkOutput("reset_done",    done_o[0],    1'b0);
        rst_n = 1'b1;

        $display("[TB] stray tx_done in IDLE, then basic abc stream with stray tx_done in SEND");
        @(negedge clk);
        stray_done[0] = 1'b1;
        @(negedge clk);
        stray_done[0] = 1'b0;
        @(negedge clk); #1;
        checkOutput("idle_stray_busy",  busy_o[0],  1'b0);
        checkOutput("idle_stray_tx_dv", tx_dv_o[0], 1'b0);
        base  = cap0.size();
        obase = ovr_cnt[0];
        applyStimulus(0, ABC, 1'b1);
        waitDone(0);
        checkOutput("abc_count",  cap0.size() - base, NB);
        checkOutput("abc_byte0",  cap0[base],      8'hba);
        checkOutput("abc_byte1",  cap0[base + 1],  8'h78);
        checkOutput("abc_byte3",  cap0[base + 3],  8'hbf);
        checkOutput("abc_byte31", cap0[base + 31], 8'had);
        checkOutput("abc_stream", packCap(cap0, base), ABC);
        checkOutput("abc_no_overrun", ovr_cnt[0] - obase, 0);

        $display("[TB] gap pacing with GAP_CYCLES=3 and immediate tx_done");
        base = cap1.size();
        applyStimulus(1, ABC, 1'b0);
        waitDone(1);
        checkOutput("gap_count",  cap1.size() - base, NB);
        checkOutput("gap_stream", packCap(cap1, base), ABC);

        $display("[TB] overrun during byte 5");
        repeat (3) @(negedge clk);
        base  = cap0.size();
        obase = ovr_cnt[0];
        applyStimulus(0, ABC, 1'b0);
        waitBytes(0, base + 5);
        applyStimulus(0, ALL_FF, 1'b0);
        waitDone(0);
        checkOutput("ovr_pulses", ovr_cnt[0] - obase, 1);
        checkOutput("ovr_count",  cap0.size() - base, NB);
        checkOutput("ovr_stream", packCap(cap0, base), ABC);

        $display("[TB] asynchronous reset after byte 10");
        repeat (3) @(negedge clk);
        base = cap0.size();
        applyStimulus(0, ABC, 1'b0);
        waitBytes(0, base + 10);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_tx_dv", tx_dv_o[0], 1'b0);
        checkOutput("midrst_busy",  busy_o[0],  1'b0);
        checkOutput("midrst_done",  done_o[0],  1'b0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        base = cap0.size();
        applyStimulus(0, SEQ, 1'b0);
        waitDone(0);
        checkOutput("seq_count",  cap0.size() - base, NB);
        checkOutput("seq_byte0",  cap0[base],      8'h00);
        checkOutput("seq_byte31", cap0[base + 31], 8'h1f);
        checkOutput("seq_stream", packCap(cap0, base), SEQ);

        $display("[TB] back-to-back digest two cycles after done");
        base  = cap0.size();
        obase = ovr_cnt[0];
        applyStimulus(0, ABC, 1'b0);
        #1;
        checkOutput("b2b_busy", busy_o[0], 1'b1);
        @(negedge clk); #1;
        checkOutput("b2b_first_dv",   tx_dv_o[0],   1'b1);
        checkOutput("b2b_first_byte", tx_byte_o[0], 8'hba);
        waitDone(0);
        checkOutput("b2b_stream",   packCap(cap0, base), ABC);
        checkOutput("b2b_overrun",  ovr_cnt[0] - obase, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
